edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Multi-channel edge-event controller that detects rising/falling transitions on `N_CH` single-bit inputs and queues one pending event per channel. It also shares a single event-output port among the channels with round-robin arbitration and a valid/ready handshake. It sits between raw level inputs (buttons, status lines, strobes) and a downstream consumer that can accept at most one event per cycle.

## Interface
- `N_CH`, default 4: number of input channels; legal range 2..32.
- `CH_W`, default `$clog2(N_CH)`: channel-index width; derived, not overridden.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in` input N_CH: level inputs. Synchronous to `clk` unless `EDGE_ARB_SYNC_EN` is defined.
- `rise_en` input N_CH: per-channel enable for rising-edge detection.
- `fall_en` input N_CH: per-channel enable for falling-edge detection.
- `evt_valid` output 1: output event register holds an event.
- `evt_ready` input 1: consumer accepts the event when `evt_valid && evt_ready`.
- `evt_ch` output CH_W: channel index of the presented event.
- `evt_rising` output 1: 1 means rising edge, 0 means falling edge.
- `overflow` output N_CH: sticky per-channel flag; a qualified edge was dropped.
- `overflow_clr` input N_CH: per-channel clear of `overflow`.

## Operation
- **Per-channel history:** `prev[i]` register, reset 0. It captures the sampled `in[i]` every cycle.
- **Edge detection:**
  - A rising edge is `in[i] & ~prev[i]`; a falling edge is `~in[i] & prev[i]`.
  - An edge is qualified when the matching enable (`rise_en[i]` or `fall_en[i]`) is 1 in the same cycle.
  - Because `prev` resets to 0, an input already high after reset yields a rising edge on the first cycle out of reset.
- **Pending slot:** one per channel, holding `pend[i]` and `pend_rise[i]`.
  - A qualified edge with the slot empty sets `pend[i]` and records the edge type.
  - A qualified edge with the slot full, and the slot not granted this cycle, drops the new edge, keeps the old one, and sets `overflow[i]`.
  - A qualified edge arriving in the same cycle the slot is granted refills the slot with the new type. No overflow is flagged.
- **Enable changes:** enables gate detection only. Deasserting an enable does not clear an event already pending.
- **Output register:**
  - `load = ~evt_valid | evt_ready`.
  - When `load` is 1 and any `pend` bit is set, grant the first pending channel searching from `ptr+1` upward, modulo N_CH.
  - On a grant: clear that channel's `pend`, load `evt_ch` and `evt_rising`, set `evt_valid`, and set `ptr` to the granted index.
  - When `load` is 1 and nothing is pending, clear `evt_valid`.
  - When `load` is 0, `evt_valid`, `evt_ch` and `evt_rising` hold unchanged. This is AXI-style: the payload is stable while valid and not ready.
- **Round-robin pointer:** `ptr` resets to N_CH-1, so channel 0 has first priority after reset. `ptr` changes only on a grant.
- **Overflow flags:** the `overflow[i]` set and `overflow_clr[i]` clear conditions can occur in the same cycle; set wins.
- **Reset:** `rst` in any cycle, including mid-handshake, clears `prev`, `pend`, `overflow` and the output register. A stalled event is lost.

## Timing
- Reset values: `evt_valid`=0, `evt_ch`=0, `evt_rising`=0, `overflow`=0.
- **Latency:**
  - `in` changes before edge k: `pend` is set at edge k, and `evt_valid` is high after edge k+1 (when the output is free).
  - That is 2 cycles from the sampled input change to a visible event.
- **Throughput:** one event per cycle while `evt_ready` is held 1.
- **Fairness:** with all channels continuously pending, each channel is granted once per N_CH accepted events.
- **Back-pressure:** `evt_ready` may be held 0 indefinitely. Pending slots absorb one event per channel; further edges raise `overflow`.
- **Input pulses:** a pulse shorter than one clock period is not guaranteed to be seen. This applies to each input change relative to sampling.

## Configuration
- **`EDGE_ARB_SYNC_EN` defined:**
  - A two-flop synchronizer (reset 0) is inserted on every `in` bit before edge detection, so `in` may be asynchronous.
  - Input-to-`evt_valid` latency becomes 4 cycles.
- **`EDGE_ARB_SYNC_EN` undefined:** `in` is sampled directly, with the 2-cycle latency above. The caller guarantees `in` is synchronous to `clk`.

## Test plan
- **Single edge:** reset, then `rise_en`=4'hF and `in[2]` 0→1 with `evt_ready`=1.
  - `evt_valid`=1 for exactly one cycle, 2 cycles later (4 with the macro), with `evt_ch`=2 and `evt_rising`=1.
  - `in[2]` 1→0 with `fall_en[2]`=0 produces no event.
- **Round-robin:** `evt_ready`=0, then edges on channels 0, 1 and 3 in one cycle; then `evt_ready`=1.
  - Accepted order is 0, 1, 3 on consecutive cycles.
  - A new edge on channel 0 during the burst is served after 3.
- **Stall and overflow:** `evt_ready`=0 and `in[1]` toggles 3 times with both enables 1.
  - The first edge reaches the output register, the second stays pending, and the third sets `overflow[1]`=1.
  - The payload stays stable for the whole stall.
- **Grant plus refill:** a new edge on channel 1 arrives in the cycle its pending event is granted.
  - The slot refills with the new type, `overflow[1]` stays 0, and two events are delivered.
- **Overflow set vs clear:** `overflow_clr[1]`=1 in the same cycle as an overflow-causing edge.
  - `overflow[1]` stays 1; a later clear alone drives it to 0.
- **Reset mid-operation:** assert `rst` for 1 cycle while `evt_valid`=1 and stalled, with two channels pending.
  - All outputs read 0 the next cycle, no stale events follow, and channel 0 has priority afterwards.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Edge detector with one pending slot per channel. A round-robin arbiter feeds one valid/ready event port.
// Latency is 2 cycles from input to evt_valid_o (4 with EDGE_ARB_SYNC_EN). The payload holds while stalled; extra edges set overflow.
module edge_event_arbiter #(
    parameter int  N_CH = 4,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] in_i,
    input  logic [N_CH-1:0] rise_en_i,
    input  logic [N_CH-1:0] fall_en_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [CH_W-1:0] evt_ch_o,
    output logic            evt_rising_o,
    output logic [N_CH-1:0] overflow_o,
    input  logic [N_CH-1:0] overflow_clr_i
);

    logic [N_CH-1:0] in_s;

`ifdef EDGE_ARB_SYNC_EN
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = in_i;
`endif

    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] pend_q,      pend_d;
    logic [N_CH-1:0] pend_rise_q, pend_rise_d;
    logic [N_CH-1:0] overflow_q,  overflow_d;
    logic [N_CH-1:0] ovf_set;
    logic            evt_valid_q,  evt_valid_d;
    logic [CH_W-1:0] evt_ch_q,     evt_ch_d;
    logic            evt_rising_q, evt_rising_d;
    logic [CH_W-1:0] ptr_q,        ptr_d;

    logic [N_CH-1:0] rise_qual;
    logic [N_CH-1:0] fall_qual;
    logic [N_CH-1:0] edge_qual;

    assign rise_qual = in_s & ~prev_q & rise_en_i;
    assign fall_qual = ~in_s & prev_q & fall_en_i;
    assign edge_qual = rise_qual | fall_qual;

    logic            load;
    logic            hi_vld,  lo_vld;
    logic [CH_W-1:0] hi_idx,  lo_idx;
    logic            hi_rise, lo_rise;
    logic            gnt_vld;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_rise;

    assign load = ~evt_valid_q | evt_ready_i;

    // Rotate priority: the first pending channel above ptr wins, else the lowest pending channel wraps around.
    always_comb begin
        hi_vld  = 1'b0;
        hi_idx  = '0;
        hi_rise = 1'b0;
        lo_vld  = 1'b0;
        lo_idx  = '0;
        lo_rise = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!hi_vld && pend_q[i] && (CH_W'(i) > ptr_q)) begin
                hi_vld  = 1'b1;
                hi_idx  = CH_W'(i);
                hi_rise = pend_rise_q[i];
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!lo_vld && pend_q[i]) begin
                lo_vld  = 1'b1;
                lo_idx  = CH_W'(i);
                lo_rise = pend_rise_q[i];
            end
        end
    end

    assign gnt_vld  = load & (hi_vld | lo_vld);
    assign gnt_idx  = hi_vld ? hi_idx  : lo_idx;
    assign gnt_rise = hi_vld ? hi_rise : lo_rise;

    always_comb begin
        pend_d      = pend_q;
        pend_rise_d = pend_rise_q;
        ovf_set     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (edge_qual[i]) begin
                // A slot being granted this cycle is free to take the new edge.
                if (!pend_q[i] || (gnt_vld && (gnt_idx == CH_W'(i)))) begin
                    pend_d[i]      = 1'b1;
                    pend_rise_d[i] = rise_qual[i];
                end else begin
                    ovf_set[i] = 1'b1;
                end
            end else if (gnt_vld && (gnt_idx == CH_W'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    assign overflow_d = ovf_set | (overflow_q & ~overflow_clr_i);

    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_ch_d     = evt_ch_q;
        evt_rising_d = evt_rising_q;
        ptr_d        = ptr_q;
        if (load) begin
            evt_valid_d = gnt_vld;
            if (gnt_vld) begin
                evt_ch_d     = gnt_idx;
                evt_rising_d = gnt_rise;
                ptr_d        = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q       <= '0;
            pend_q       <= '0;
            pend_rise_q  <= '0;
            overflow_q   <= '0;
            evt_valid_q  <= 1'b0;
            evt_ch_q     <= '0;
            evt_rising_q <= 1'b0;
            ptr_q        <= CH_W'(N_CH - 1);
        end else begin
            prev_q       <= in_s;
            pend_q       <= pend_d;
            pend_rise_q  <= pend_rise_d;
            overflow_q   <= overflow_d;
            evt_valid_q  <= evt_valid_d;
            evt_ch_q     <= evt_ch_d;
            evt_rising_q <= evt_rising_d;
            ptr_q        <= ptr_d;
        end
    end

    assign evt_valid_o  = evt_valid_q;
    assign evt_ch_o     = evt_ch_q;
    assign evt_rising_o = evt_rising_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with N_CH=4; expected values are hand-derived per scenario.
module tb_edge_event_arbiter;

`ifdef EDGE_ARB_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_v;
    logic [3:0] rise_en;
    logic [3:0] fall_en;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_rising;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N_CH(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_i           (in_v),
        .rise_en_i      (rise_en),
        .fall_en_i      (fall_en),
        .evt_valid_o    (evt_valid),
        .evt_ready_i    (evt_ready),
        .evt_ch_o       (evt_ch),
        .evt_rising_o   (evt_rising),
        .overflow_o     (ovf),
        .overflow_clr_i (ovf_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_v      = 4'b0000;
        rise_en   = 4'b0000;
        fall_en   = 4'b0000;
        ovf_clr   = 4'b0000;
        evt_ready = 1'b0;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({evt_valid, evt_ch, evt_rising} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_out: got %b want %b", {evt_valid, evt_ch, evt_rising}, 4'b0000);
        end
        vectors++;
        if (ovf !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ovf: got %b want %b", ovf, 4'b0000);
        end
    endtask

    task automatic test_single_edge();
        do_reset();
        rise_en   = 4'hF;
        evt_ready = 1'b1;
        in_v      = 4'b0100;
        for (int c = 0; c < 1 + EXTRA; c++) begin
            step();
            vectors++;
            if (evt_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL single_early cyc%0d: got valid %b want 0", c, evt_valid);
            end
        end
        step();
        vectors++;
        if ({evt_valid, evt_ch, evt_rising} !== {1'b1, 2'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL single_evt: got %b want %b", {evt_valid, evt_ch, evt_rising}, {1'b1, 2'd2, 1'b1});
        end
        step();
        vectors++;
        if (evt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_one_cycle: got valid %b want 0", evt_valid);
        end
        in_v = 4'b0000;
        for (int c = 0; c < 4 + EXTRA; c++) begin
            step();
            vectors++;
            if (evt_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL single_fall_masked cyc%0d: got valid %b want 0", c, evt_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [4];
        exp_seq[0] = {1'b1, 2'd1, 1'b1};
        exp_seq[1] = {1'b1, 2'd3, 1'b1};
        exp_seq[2] = {1'b1, 2'd0, 1'b1};
        exp_seq[3] = {1'b0, 2'd0, 1'b1};
        do_reset();
        rise_en = 4'hF;
        in_v    = 4'b1011;
        step();
        step();
        vectors++;
        if ({evt_valid, evt_ch, evt_rising} !== {1'b1, 2'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL rr_first: got %b want %b", {evt_valid, evt_ch, evt_rising}, {1'b1, 2'd0, 1'b1});
        end
        in_v = 4'b1010;
        for (int c = 0; c < 2; c++) begin
            step();
            vectors++;
            if ({evt_valid, evt_ch, evt_rising} !== {1'b1, 2'd0, 1'b1}) begin
                miscompares++;
                $display("FAIL rr_stall cyc%0d: got %b want %b", c, {evt_valid, evt_ch, evt_rising}, {1'b1, 2'd0, 1'b1});
            end
        end
        in_v      = 4'b1011;
        evt_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if (c == 3 ? (evt_valid !== 1'b0) : ({evt_valid, evt_ch, evt_rising} !== exp_seq[c])) begin
                miscompares++;
                $display("FAIL rr_order step%0d: got %b want %b", c, {evt_valid, evt_ch, evt_rising}, exp_seq[c]);
            end
        end
    endtask

    task automatic test_stall_overflow();
        do_reset();
        rise_en = 4'hF;
        fall_en = 4'hF;
        in_v    = 4'b0010;
        step();
        vectors++;
        if (evt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_e1: got valid %b want 0", evt_valid);
        end
        in_v = 4'b0000;
        step();
        vectors++;
        if ({evt_valid, evt_ch, evt_rising, ovf} !== {1'b1, 2'd1, 1'b1, 4'b0000}) begin
            miscompares++;
            $display("FAIL stall_e2: got %b want %b", {evt_valid, evt_ch, evt_rising, ovf}, {1'b1, 2'd1, 1'b1, 4'b0000});
        end
        in_v = 4'b0010;
        step();
        vectors++;
        if (ovf !== 4'b0010) begin
            miscompares++;
            $display("FAIL stall_ovf: got %b want %b", ovf, 4'b0010);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if ({evt_valid, evt_ch, evt_rising} !== {1'b1, 2'd1, 1'b1}) begin
                miscompares++;
                $display("FAIL stall_stable cyc%0d: got %b want %b", c, {evt_valid, evt_ch, evt_rising}, {1'b1, 2'd1, 1'b1});
            end
        end
        evt_ready = 1'b1;
        step();
        vectors++;
        if ({evt_valid, evt_ch, evt_rising} !== {1'b1, 2'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_second: got %b want %b", {evt_valid, evt_ch, evt_rising}, {1'b1, 2'd1, 1'b0});
        end
        step();
        vectors++;
        if ({evt_valid, ovf} !== {1'b0, 4'b0010}) begin
            miscompares++;
            $display("FAIL stall_drain: got %b want %b", {evt_valid, ovf}, {1'b0, 4'b0010});
        end
    endtask

    task automatic test_grant_refill();
        do_reset();
        rise_en   = 4'hF;
        fall_en   = 4'hF;
        evt_ready = 1'b1;
        in_v      = 4'b0010;
        step();
        in_v = 4'b0000;
        step();
        vectors++;
        if ({evt_valid, evt_ch, evt_rising, ovf} !== {1'b1, 2'd1, 1'b1, 4'b0000}) begin
            miscompares++;
            $display("FAIL refill_first: got %b want %b", {evt_valid, evt_ch, evt_rising, ovf}, {1'b1, 2'd1, 1'b1, 4'b0000});
        end
        step();
        vectors++;
        if ({evt_valid, evt_ch, evt_rising, ovf} !== {1'b1, 2'd1, 1'b0, 4'b0000}) begin
            miscompares++;
            $display("FAIL refill_second: got %b want %b", {evt_valid, evt_ch, evt_rising, ovf}, {1'b1, 2'd1, 1'b0, 4'b0000});
        end
        step();
        vectors++;
        if ({evt_valid, ovf} !== {1'b0, 4'b0000}) begin
            miscompares++;
            $display("FAIL refill_drain: got %b want %b", {evt_valid, ovf}, {1'b0, 4'b0000});
        end
    endtask

    task automatic test_ovf_set_clr();
        do_reset();
        rise_en = 4'hF;
        fall_en = 4'hF;
        in_v    = 4'b0010;
        step();
        in_v = 4'b0000;
        step();
        in_v    = 4'b0010;
        ovf_clr = 4'b0010;
        step();
        vectors++;
        if (ovf !== 4'b0010) begin
            miscompares++;
            $display("FAIL ovf_set_wins: got %b want %b", ovf, 4'b0010);
        end
        step();
        vectors++;
        if (ovf !== 4'b0000) begin
            miscompares++;
            $display("FAIL ovf_clear: got %b want %b", ovf, 4'b0000);
        end
        ovf_clr = 4'b0000;
        step();
        vectors++;
        if (ovf !== 4'b0000) begin
            miscompares++;
            $display("FAIL ovf_stays_clear: got %b want %b", ovf, 4'b0000);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rise_en = 4'hF;
        in_v    = 4'b1110;
        step();
        step();
        vectors++;
        if ({evt_valid, evt_ch, evt_rising} !== {1'b1, 2'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid_pre: got %b want %b", {evt_valid, evt_ch, evt_rising}, {1'b1, 2'd1, 1'b1});
        end
        rst  = 1'b1;
        in_v = 4'b0000;
        step();
        rst = 1'b0;
        vectors++;
        if ({evt_valid, evt_ch, evt_rising, ovf} !== 8'h00) begin
            miscompares++;
            $display("FAIL rstmid_out: got %b want %b", {evt_valid, evt_ch, evt_rising, ovf}, 8'h00);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (evt_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_stale cyc%0d: got valid %b want 0", c, evt_valid);
            end
        end
        in_v = 4'b1001;
        step();
        step();
        vectors++;
        if ({evt_valid, evt_ch, evt_rising} !== {1'b1, 2'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid_prio: got %b want %b", {evt_valid, evt_ch, evt_rising}, {1'b1, 2'd0, 1'b1});
        end
        evt_ready = 1'b1;
        step();
        vectors++;
        if ({evt_valid, evt_ch, evt_rising} !== {1'b1, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid_next: got %b want %b", {evt_valid, evt_ch, evt_rising}, {1'b1, 2'd3, 1'b1});
        end
        step();
        vectors++;
        if (evt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_drain: got valid %b want 0", evt_valid);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_edge();
        test_round_robin();
        test_stall_overflow();
        test_grant_refill();
        test_ovf_set_clr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
